dfd_trace_mem_reader: RTL
=========================

# dfd_trace_mem_reader

Readback engine for the trace sink SRAM array. Once tracing is stopped, it takes a read request (start word, length) and issues single-word reads across the `TRC_RAM_INSTANCES` sink RAMs, absorbing their 1-cycle read latency. It returns words on a valid/ready stream toward the debug register/bus side. It drives the read side of the same RAM packet interface the sink's write path uses; the top level muxes RAM ownership to this block while `o_rd_busy` is high.

## Interface
Parameters:
- `TRC_RAM_INSTANCES`, 8: number of sink RAM instances; power of 2.
- `TRC_RAM_INDEX_WIDTH`, 9: per-instance address width.
- `TRC_RAM_DATA_WIDTH`, 64: word width.
- Derived: `IW = log2(TRC_RAM_INSTANCES)`, `AW = IW + TRC_RAM_INDEX_WIDTH`, `DEPTH = 2**AW`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_trace_active`  in  1  trace capture running; the reader must not own the RAMs.
- `i_req_valid`  in  1  read request valid.
- `o_req_ready`  out  1  request accept; equals `(state==IDLE) & ~i_trace_active`.
- `i_req_start_addr`  in  AW  flat start word; `[AW-1:TRC_RAM_INDEX_WIDTH]` is the instance, low bits are the index.
- `i_req_len`  in  AW+1  words to read; legal range is 1..DEPTH.
- `i_abort`  in  1  cancel the current operation.
- `o_mem_chip_en`  out  TRC_RAM_INSTANCES  one-hot read enable.
- `o_mem_wr_en`  out  TRC_RAM_INSTANCES  constant 0.
- `o_mem_wr_mask_en`  out  TRC_RAM_INSTANCES  constant 0.
- `o_mem_addr`  out  TRC_RAM_INDEX_WIDTH  index, shared by all instances.
- `i_mem_rd_data`  in  TRC_RAM_INSTANCES x TRC_RAM_DATA_WIDTH  per-instance read data, valid the cycle after chip_en.
- `o_data_valid`  out  1  output word valid.
- `i_data_ready`  in  1  output word accept.
- `o_data`  out  TRC_RAM_DATA_WIDTH  output word.
- `o_data_last`  out  1  final word of the request.
- `o_rd_busy`  out  1  `state != IDLE`.
- `o_done`  out  1  1-cycle pulse when the last word is accepted.
- `o_err`  out  1  1-cycle pulse on an illegal request or a trace restart mid-read.

## Operation
- States:
  - IDLE
    - Accept when `i_req_valid & o_req_ready`.
    - If `i_req_len` is 0 or greater than DEPTH: pulse `o_err`, stay IDLE.
    - Otherwise load `rd_ptr = start`, `issue_rem = len`, `beat_rem = len`, go to READ.
  - READ
    - Issue one read per cycle while `issue_rem != 0` and `fifo_cnt + inflight < 3`.
    - Issuing means: chip_en bit `rd_ptr[AW-1:TRC_RAM_INDEX_WIDTH]`, addr `rd_ptr[TRC_RAM_INDEX_WIDTH-1:0]`, `rd_ptr++` modulo DEPTH, `issue_rem--`.
    - Go to DRAIN in the cycle the last read issues.
  - DRAIN
    - No issues.
    - Go to IDLE when the last word is accepted (`o_data_valid & o_data_last & i_data_ready`); `o_done` pulses that cycle.
- Wrap-around: `rd_ptr` wraps from DEPTH-1 to 0. Crossing from instance k to k+1 happens with no bubble.
- Return path:
  - `inflight` (1 bit) and `inflight_inst` (IW bits) are registered at issue.
  - The next cycle, `i_mem_rd_data[inflight_inst]` is pushed into a 3-entry FIFO.
  - The credit rule guarantees the FIFO never overflows. It gives full throughput with no combinational path from `i_data_ready` to `o_mem_chip_en`.
- Output:
  - Words come from the FIFO head.
  - `o_data_last` is 1 when `beat_rem == 1`.
  - `beat_rem--` on each accept.
  - `o_data` is stable while `valid & ~ready`.
- Abort (`i_abort`, any non-IDLE state):
  - Next cycle: IDLE, FIFO flushed, inflight data dropped, no `o_done`.
  - `i_abort` in IDLE is ignored.
- `i_trace_active` rising while busy is treated as an abort and also pulses `o_err`.
- Simultaneous abort and last-word accept: the accept completes and `o_done` pulses; abort has no further effect.

## Timing
- Reset values:
  - All outputs 0, state IDLE, FIFO empty, inflight 0.
  - After reset, `o_req_ready` follows `~i_trace_active` combinationally.
- Request accepted at edge E:
  - First chip_en is in cycle E+1.
  - Its data is on `i_mem_rd_data` in E+2.
  - `o_data_valid` rises in E+3.
- Latency from accept to first word: 3 cycles.
- With `i_data_ready` held high, one word per cycle; an N-word read finishes with `o_done` in cycle E+N+2.
- Backpressure:
  - At most 3 words are outstanding (FIFO + inflight).
  - Issue resumes in the cycle after the first pop.
- `o_rd_busy` rises at E+1 and falls the cycle after `o_done`.

## Test plan
- Reset, then `start=0x010`, `len=4`, ready=1 -> chip_en[0] for addr 0x10..0x13 in cycles E+1..E+4; 4 words in E+3..E+6; last and `o_done` at E+6; the RAM pattern is matched exactly.
- Instance crossing and wrap: `start=0xFFE`, `len=4` (defaults) -> reads inst7/0x1FE, inst7/0x1FF, inst0/0x000, inst0/0x001 with no bubble.
- Backpressure: `len=8`, `i_data_ready` toggling randomly -> never more than 3 outstanding; no loss or duplication; `o_data` stable while stalled.
- Illegal requests: `len=0` and `len=4097` -> `o_err` pulse, `o_rd_busy` stays 0. Request with `i_trace_active=1` -> `o_req_ready=0`, not accepted.
- Abort at word 2 of `len=16` -> IDLE next cycle, `o_data_valid` 0, no `o_done`. A new request is accepted and returns correct data.
- `i_trace_active` rises mid-read -> `o_err` pulse, abort behaviour as above. Async reset asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/dfd_trace_mem_reader.sv
// Readback engine for the trace sink RAMs: walks a flat word range across all
// instances, absorbs the 1-cycle RAM latency and streams words out on valid/ready.
module dfd_trace_mem_reader #(
    parameter int TRC_RAM_INSTANCES   = 8,
    parameter int TRC_RAM_INDEX_WIDTH = 9,
    parameter int TRC_RAM_DATA_WIDTH  = 64,
    localparam int IW = $clog2(TRC_RAM_INSTANCES),
    localparam int AW = IW + TRC_RAM_INDEX_WIDTH
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  i_trace_active,
    input  logic                                                  i_req_valid,
    output logic                                                  o_req_ready,
    input  logic [AW-1:0]                                         i_req_start_addr,
    input  logic [AW:0]                                           i_req_len,
    input  logic                                                  i_abort,
    output logic [TRC_RAM_INSTANCES-1:0]                          o_mem_chip_en,
    output logic [TRC_RAM_INSTANCES-1:0]                          o_mem_wr_en,
    output logic [TRC_RAM_INSTANCES-1:0]                          o_mem_wr_mask_en,
    output logic [TRC_RAM_INDEX_WIDTH-1:0]                        o_mem_addr,
    input  logic [TRC_RAM_INSTANCES-1:0][TRC_RAM_DATA_WIDTH-1:0]  i_mem_rd_data,
    output logic                                                  o_data_valid,
    input  logic                                                  i_data_ready,
    output logic [TRC_RAM_DATA_WIDTH-1:0]                         o_data,
    output logic                                                  o_data_last,
    output logic                                                  o_rd_busy,
    output logic                                                  o_done,
    output logic                                                  o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Output stream: a word moves when o_data_valid & i_data_ready in the same cycle;
    // once valid is high, o_data holds until that happens.

    logic [1:0]                    r_state;
    logic [AW-1:0]                 r_rd_ptr;
    logic [AW:0]                   r_issue_rem;
    logic [AW:0]                   r_beat_rem;
    logic                          r_inflight;
    logic [IW-1:0]                 r_inflight_inst;
    logic [TRC_RAM_DATA_WIDTH-1:0] r_fifo [3];
    logic [1:0]                    r_wr_idx;
    logic [1:0]                    r_rd_idx;
    logic [1:0]                    r_cnt;
    logic                          r_err;

    logic w_busy, w_accept, w_len_bad, w_valid, w_pop, w_push;
    logic w_done, w_kill, w_credit, w_issue;

    assign w_busy    = (r_state != ST_IDLE);
    assign o_req_ready = (r_state == ST_IDLE) & ~i_trace_active;
    assign w_accept  = i_req_valid & o_req_ready;
    assign w_len_bad = (i_req_len == '0) | (i_req_len > {1'b1, {AW{1'b0}}});
    assign w_valid   = (r_cnt != 2'd0);
    assign w_pop     = w_valid & i_data_ready;
    assign w_push    = r_inflight;
    assign w_done    = w_busy & w_pop & (r_beat_rem == (AW+1)'(1));
    // A trace restart behaves like an abort; a last-word accept in the same cycle still completes.
    assign w_kill    = w_busy & (i_abort | i_trace_active) & ~w_done;
    // Credit counts FIFO occupancy plus the read in flight, so issue never depends on i_data_ready.
    assign w_credit  = (({1'b0, r_cnt} + {2'b00, r_inflight}) < 3'd3);
    assign w_issue   = (r_state == ST_READ) & (r_issue_rem != '0) & w_credit & ~w_kill;

    assign o_mem_chip_en    = w_issue ? (TRC_RAM_INSTANCES'(1) << r_rd_ptr[AW-1:TRC_RAM_INDEX_WIDTH]) : '0;
    assign o_mem_addr       = w_issue ? r_rd_ptr[TRC_RAM_INDEX_WIDTH-1:0] : '0;
    assign o_mem_wr_en      = '0;
    assign o_mem_wr_mask_en = '0;

    assign o_data_valid = w_valid;
    assign o_data       = w_valid ? r_fifo[r_rd_idx] : '0;
    assign o_data_last  = w_valid & (r_beat_rem == (AW+1)'(1));
    assign o_rd_busy    = w_busy;
    assign o_done       = w_done;
    assign o_err        = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_rd_ptr        <= '0;
            r_issue_rem     <= '0;
            r_beat_rem      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_inst <= '0;
            r_wr_idx        <= 2'd0;
            r_rd_idx        <= 2'd0;
            r_cnt           <= 2'd0;
            r_err           <= 1'b0;
        end else begin
            r_err <= (w_accept & w_len_bad) | (w_busy & i_trace_active & ~w_done);
            if (w_kill) begin
                r_state    <= ST_IDLE;
                r_inflight <= 1'b0;
                r_wr_idx   <= 2'd0;
                r_rd_idx   <= 2'd0;
                r_cnt      <= 2'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && !w_len_bad) begin
                            r_rd_ptr    <= i_req_start_addr;
                            r_issue_rem <= i_req_len;
                            r_beat_rem  <= i_req_len;
                            r_state     <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (w_issue && r_issue_rem == (AW+1)'(1)) r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (w_done) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_inst <= r_rd_ptr[AW-1:TRC_RAM_INDEX_WIDTH];
                    r_rd_ptr        <= r_rd_ptr + AW'(1);
                    r_issue_rem     <= r_issue_rem - (AW+1)'(1);
                end
                if (w_pop) begin
                    r_beat_rem <= r_beat_rem - (AW+1)'(1);
                    r_rd_idx   <= (r_rd_idx == 2'd2) ? 2'd0 : r_rd_idx + 2'd1;
                end
                if (w_push) begin
                    r_wr_idx <= (r_wr_idx == 2'd2) ? 2'd0 : r_wr_idx + 2'd1;
                end
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // Data storage needs no reset: o_data is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_idx] <= i_mem_rd_data[r_inflight_inst];
    end

endmodule
